// File: rtl/descriptor_fetcher.sv
// Avalon-MM master walking a linked chain of 4-word DMA descriptors.
// Optional zero-length rejection: define DESC_FETCHER_LEN_CHECK_EN.
module descriptor_fetcher #(
  parameter int ADDR_W = 9,
  parameter int LEN_W  = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_ptr,
  input  logic              stop,
  output logic              busy,
  output logic              chain_end,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [3:0]        mem_byteenable,
  output logic [31:0]       mem_writedata,
  output logic              mem_clken,
  input  logic [31:0]       mem_readdata,
  output logic              desc_valid,
  input  logic              desc_ready,
  output logic [31:0]       desc_buf_addr,
  output logic [LEN_W-1:0]  desc_len,
  output logic              desc_eop,
  input  logic              done_valid,
  input  logic [LEN_W-1:0]  done_len
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_FETCH     = 3'd1;
  localparam logic [2:0] S_CHECK     = 3'd2;
  localparam logic [2:0] S_PRESENT   = 3'd3;
  localparam logic [2:0] S_WAIT_DONE = 3'd4;
  localparam logic [2:0] S_WRITEBACK = 3'd5;
  localparam logic [2:0] S_NEXT      = 3'd6;

  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

  logic [2:0]        state_reg;
  logic [ADDR_W-1:0] ptr_reg;
  logic [2:0]        cnt_reg;
  logic [31:0]       buf_addr_reg;
  logic [LEN_W-1:0]  len_reg;
  logic [ADDR_W-1:0] next_ptr_reg;
  logic              owned_reg;
  logic              eop_reg;
  logic              eol_reg;
  logic [LEN_W-1:0]  done_len_reg;
  logic              chain_end_reg;
  logic              err_bit;

`ifdef DESC_FETCHER_LEN_CHECK_EN
  logic              err_reg;
  assign err_bit = err_reg;
`else
  assign err_bit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg     <= S_IDLE;
      ptr_reg       <= '0;
      cnt_reg       <= '0;
      buf_addr_reg  <= '0;
      len_reg       <= '0;
      next_ptr_reg  <= '0;
      owned_reg     <= 1'b0;
      eop_reg       <= 1'b0;
      eol_reg       <= 1'b0;
      done_len_reg  <= '0;
      chain_end_reg <= 1'b0;
`ifdef DESC_FETCHER_LEN_CHECK_EN
      err_reg       <= 1'b0;
`endif
    end else begin
      chain_end_reg <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (start) begin
            ptr_reg   <= start_ptr & ALIGN_MASK;
            cnt_reg   <= '0;
            state_reg <= S_FETCH;
          end
        end
        S_FETCH: begin
          // Read data trails its address by one cycle, so capture slot N
          // belongs to the address issued when cnt_reg was N-1.
          cnt_reg <= cnt_reg + 3'd1;
          case (cnt_reg)
            3'd1: buf_addr_reg <= mem_readdata;
            3'd2: len_reg      <= mem_readdata[LEN_W-1:0];
            3'd3: next_ptr_reg <= mem_readdata[ADDR_W-1:0] & ALIGN_MASK;
            3'd4: begin
              owned_reg <= mem_readdata[31];
              eop_reg   <= mem_readdata[30];
              eol_reg   <= mem_readdata[29];
              state_reg <= S_CHECK;
            end
            default: ;
          endcase
        end
        S_CHECK: begin
          if (!owned_reg) begin
            chain_end_reg <= 1'b1;
            state_reg     <= S_IDLE;
          end
`ifdef DESC_FETCHER_LEN_CHECK_EN
          else if (len_reg == '0) begin
            err_reg      <= 1'b1;
            done_len_reg <= '0;
            state_reg    <= S_WRITEBACK;
          end else begin
            err_reg   <= 1'b0;
            state_reg <= S_PRESENT;
          end
`else
          else begin
            state_reg <= S_PRESENT;
          end
`endif
        end
        S_PRESENT: begin
          if (desc_ready) state_reg <= S_WAIT_DONE;
        end
        S_WAIT_DONE: begin
          if (done_valid) begin
            done_len_reg <= done_len;
            state_reg    <= S_WRITEBACK;
          end
        end
        S_WRITEBACK: state_reg <= S_NEXT;
        S_NEXT: begin
          if (eol_reg || stop) begin
            chain_end_reg <= 1'b1;
            state_reg     <= S_IDLE;
          end else begin
            ptr_reg   <= next_ptr_reg;
            cnt_reg   <= '0;
            state_reg <= S_FETCH;
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    mem_chipselect = 1'b0;
    mem_write      = 1'b0;
    mem_address    = '0;
    mem_writedata  = '0;
    if (state_reg == S_FETCH && cnt_reg != 3'd4) begin
      mem_chipselect = 1'b1;
      mem_address    = ptr_reg + ADDR_W'(cnt_reg);
    end else if (state_reg == S_WRITEBACK) begin
      mem_chipselect = 1'b1;
      mem_write      = 1'b1;
      mem_address    = ptr_reg + ADDR_W'(3);
      mem_writedata  = {1'b0, eop_reg, eol_reg, 1'b1, err_bit,
                        {(27-LEN_W){1'b0}}, done_len_reg};
    end
  end

  assign mem_byteenable = 4'hF;
  assign mem_clken      = 1'b1;
  assign busy           = (state_reg != S_IDLE);
  assign chain_end      = chain_end_reg;
  assign desc_valid     = (state_reg == S_PRESENT);
  assign desc_buf_addr  = buf_addr_reg;
  assign desc_len       = len_reg;
  assign desc_eop       = eop_reg;

endmodule
